// File: rtl/msrom_pkg.sv
// Shared constants and FSM encoding for the sound-ROM word responder.
package msrom_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2
   } state_t;

   localparam int WORD_W  = 16;
   localparam int ADDR_W  = 17;
   localparam int BADDR_W = ADDR_W + 1;

endpackage

// File: rtl/msrom.sv
// Sound-ROM word responder: two byte reads from an 8-bit async ROM per 16-bit
// word, with a one-deep pending buffer and direct chaining in the ack cycle.
module msrom
   import msrom_pkg::*;
#(
   parameter int WAIT = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               msreq,
   input  logic [ADDR_W-1:0]  msaddr,
   output logic               msack,
   output logic [WORD_W-1:0]  msdata,
   output logic               busy,
   output logic               overrun,
   output logic [BADDR_W-1:0] memaddr,
   output logic               memce_n,
   output logic               memoe_n,
   input  logic [7:0]         memdata
);

   localparam logic [3:0] WAIT_LD = 4'(WAIT - 1);

   state_t              state, state_n;
   logic [3:0]          cnt;
   logic                last;
   logic                start;
   logic [ADDR_W-1:0]   start_addr;
   logic                pend_vld;
   logic [ADDR_W-1:0]   pend_addr;
   logic                ovr;
   logic                overwrite;
   logic [7:0]          lo_byte;

   assign last      = (cnt == 4'd0);
   assign overwrite = msreq & pend_vld & ~rst;
   assign overrun   = ovr | overwrite;

   // The ack cycle is an IDLE cycle; it counts as busy only when a new access chains.
   assign busy    = (state != IDLE) | (msack & (msreq | pend_vld) & ~rst);
   assign memce_n = ~busy;
   assign memoe_n = ~busy;

   always_comb begin
      state_n    = state;
      start      = 1'b0;
      start_addr = msreq ? msaddr : pend_addr;
      case (state)
         IDLE: begin
            if (msreq | pend_vld) begin
               start   = 1'b1;
               state_n = LO;
            end
         end
         LO:      if (last) state_n = HI;
         HI:      if (last) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= 4'd0;
         pend_vld <= 1'b0;
         ovr      <= 1'b0;
         msack    <= 1'b0;
         msdata   <= '0;
         memaddr  <= '0;
      end else begin
         msack <= (state == HI) && last;
         if (overwrite) ovr <= 1'b1;
         case (state)
            IDLE: begin
               if (start) begin
                  memaddr  <= {start_addr, 1'b0};
                  cnt      <= WAIT_LD;
                  pend_vld <= 1'b0;
               end
            end
            LO: begin
               if (last) begin
                  memaddr[0] <= 1'b1;
                  cnt        <= WAIT_LD;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            HI: begin
               if (last) msdata <= {memdata, lo_byte};
               else      cnt    <= cnt - 4'd1;
            end
            default: cnt <= 4'd0;
         endcase
         if ((state != IDLE) && msreq) pend_vld <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if ((state != IDLE) && msreq) pend_addr <= msaddr;
      if ((state == LO) && last)    lo_byte   <= memdata;
   end

endmodule
